// File: rtl/eth_cfg_sequencer.sv
// eth_cfg_sequencer: programs MAC, IP and UDP ports into the Ethernet bridge config port,
// holding RX disabled for a quiesce window around each sequence.
module eth_cfg_sequencer #(
   parameter int N_UDP      = 4,
   parameter int GAP        = 1,
   parameter int QUIESCE    = 16,
   parameter int AUTO_START = 1
) (
   input  logic                 cfg_clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 auto_update,
   input  logic [31:0]          ip,
   input  logic [47:0]          mac,
   input  logic [16*N_UDP-1:0]  udp_ports,
   output logic                 cfg_enable_rx,
   output logic                 cfg_valid,
   output logic [4:0]           cfg_addr,
   output logic [7:0]           cfg_wdata,
   output logic                 busy,
   output logic                 done,
   output logic [7:0]           prog_count
);
   localparam int W = 10 + 2*N_UDP;
   localparam logic [2:0] IDLE = 3'd0, QUIE = 3'd1, WRITE = 3'd2, GAPS = 3'd3, RUN = 3'd4;

   logic [2:0]          state;
   logic [7:0]          qcnt;
   logic [3:0]          gcnt;
   logic [4:0]          k, j;
   logic                fresh, pending, trig, last, go, fin;
   logic [31:0]         snap_ip;
   logic [47:0]         snap_mac;
   logic [16*N_UDP-1:0] snap_ports;
   logic [7:0]          byte_sel;

   // change detect looks only at the snapshot identity; udp_ports never retrigger
   assign trig = start | (auto_update & ({ip, mac} != {snap_ip, snap_mac}));
   assign last = k == 5'(W-1);
   assign j    = k - 5'd10;
   assign go   = state == IDLE ? (start | (AUTO_START != 0 && fresh)) :
                 state == RUN & (trig | pending);
   assign fin  = last & ((state == WRITE && GAP == 0) || (state == GAPS && gcnt == 4'd0));

   always_comb begin
      byte_sel = k < 5'd6  ? 8'(snap_mac >> (8*(5-int'(k)))) :
                 k < 5'd10 ? 8'(snap_ip  >> (8*(9-int'(k)))) :
                             8'(snap_ports >> (16*int'(j[4:1]) + (j[0] ? 0 : 8)));
   end

   assign busy          = state == QUIE || state == WRITE || state == GAPS;
   assign cfg_enable_rx = state == RUN;
   assign cfg_valid     = state == WRITE;
   assign cfg_addr      = cfg_valid ? (k < 5'd10 ? {1'b0, k[3:0]} : {1'b1, j[3:0]}) : 5'd0;
   assign cfg_wdata     = cfg_valid ? byte_sel : 8'd0;

   always_ff @(posedge cfg_clk) begin
      if (rst) begin
         state      <= IDLE;
         qcnt       <= '0;
         gcnt       <= '0;
         k          <= '0;
         fresh      <= 1'b1;
         pending    <= 1'b0;
         done       <= 1'b0;
         prog_count <= '0;
         snap_ip    <= '0;
         snap_mac   <= '0;
         snap_ports <= '0;
      end else begin
         fresh   <= 1'b0;
         done    <= 1'b0;
         pending <= go ? 1'b0 : pending | (busy & trig);
         if (go) begin
            state      <= QUIE;
            qcnt       <= 8'(QUIESCE-1);
            snap_ip    <= ip;
            snap_mac   <= mac;
            snap_ports <= udp_ports;
         end else if (fin) begin
            state      <= RUN;
            done       <= 1'b1;
            prog_count <= prog_count + 8'd1;
         end else begin
            case (state)
               QUIE: begin
                  if (qcnt == 8'd0) begin
                     state <= WRITE;
                     k     <= '0;
                  end else qcnt <= qcnt - 8'd1;
               end
               WRITE: begin
                  if (GAP == 0) k <= k + 5'd1;
                  else begin
                     state <= GAPS;
                     gcnt  <= 4'(GAP-1);
                  end
               end
               GAPS: begin
                  if (gcnt != 4'd0) gcnt <= gcnt - 4'd1;
                  else begin
                     state <= WRITE;
                     k     <= k + 5'd1;
                  end
               end
               IDLE, RUN: state <= state;
               default: state <= IDLE;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_eth_cfg_sequencer.sv
// tb_eth_cfg_sequencer: directed checks of two sequencers, GAP=1/auto-start and GAP=0/manual-start.
module tb_eth_cfg_sequencer;
   logic clk = 0;
   always #5 clk = ~clk;

   logic rst_a = 1, rst_b = 1, start_a = 0, start_b = 0, au_a = 0;
   logic [31:0] ip    = 32'hC0A80704;
   logic [47:0] mac   = 48'h112233445566;
   logic [63:0] ports = {16'h3039, 16'h0050, 16'h0BB8, 16'h1F90};

   logic a_en, a_val, a_busy, a_done, b_en, b_val, b_busy, b_done;
   logic [4:0] a_addr, b_addr;
   logic [7:0] a_wd, b_wd, a_pc, b_pc;

   eth_cfg_sequencer dut_a (
      .cfg_clk(clk), .rst(rst_a), .start(start_a), .auto_update(au_a),
      .ip(ip), .mac(mac), .udp_ports(ports),
      .cfg_enable_rx(a_en), .cfg_valid(a_val), .cfg_addr(a_addr), .cfg_wdata(a_wd),
      .busy(a_busy), .done(a_done), .prog_count(a_pc));

   eth_cfg_sequencer #(.GAP(0), .AUTO_START(0)) dut_b (
      .cfg_clk(clk), .rst(rst_b), .start(start_b), .auto_update(1'b0),
      .ip(ip), .mac(mac), .udp_ports(ports),
      .cfg_enable_rx(b_en), .cfg_valid(b_val), .cfg_addr(b_addr), .cfg_wdata(b_wd),
      .busy(b_busy), .done(b_done), .prog_count(b_pc));

   typedef struct {int c; logic [4:0] a; logic [7:0] d;} wr_t;
   wr_t wa[$], wb[$];
   int da[$], db[$], ea[$], eb[$];
   int cyc = 0, checks = 0, errors = 0, t;
   logic pa_en = 0, pb_en = 0;
   logic [7:0] exp_d[18];

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (a_val) wa.push_back('{cyc, a_addr, a_wd});
      if (b_val) wb.push_back('{cyc, b_addr, b_wd});
      if (a_done) da.push_back(cyc);
      if (b_done) db.push_back(cyc);
      if (a_en && !pa_en) ea.push_back(cyc);
      if (b_en && !pb_en) eb.push_back(cyc);
      pa_en = a_en;
      pb_en = b_en;
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
      checks++;
      assert (o === e) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, o, e);
      end
   endtask

   task automatic set_exp(input logic [47:0] m, input logic [31:0] i);
      for (int k = 0; k < 6; k++) exp_d[k] = m[47-8*k -: 8];
      for (int k = 0; k < 4; k++) exp_d[6+k] = i[31-8*k -: 8];
      exp_d[10] = 8'h1F; exp_d[11] = 8'h90; exp_d[12] = 8'h0B; exp_d[13] = 8'hB8;
      exp_d[14] = 8'h00; exp_d[15] = 8'h50; exp_d[16] = 8'h30; exp_d[17] = 8'h39;
   endtask

   task automatic clear_q(input bit sel);
      if (sel) begin wb.delete(); db.delete(); eb.delete(); end
      else begin wa.delete(); da.delete(); ea.delete(); end
   endtask

   // expected write k of a sequence triggered at cycle t0: cycle t0+17+k*(gap+1)
   task automatic check_seq(input bit sel, input int base, input int t0, input int gap, input string tag);
      wr_t w;
      int n, dc, ec;
      for (int k = 0; k < 18; k++) begin
         n = sel ? wb.size() : wa.size();
         if (base + k < n) w = sel ? wb[base+k] : wa[base+k];
         else begin w.c = -1; w.a = '1; w.d = '1; end
         chk($sformatf("%s_w%0d", tag, k), {32'(w.c), 19'd0, w.a, w.d},
             {32'(t0 + 17 + k*(gap+1)), 19'd0, 5'(k < 10 ? k : k + 6), exp_d[k]});
      end
      n  = sel ? db.size() : da.size();
      dc = (base/18 < n) ? (sel ? db[base/18] : da[base/18]) : -1;
      n  = sel ? eb.size() : ea.size();
      ec = (base/18 < n) ? (sel ? eb[base/18] : ea[base/18]) : -1;
      chk({tag, "_done"}, 64'(dc), 64'(t0 + 17 + 18*(gap+1)));
      chk({tag, "_en"},   64'(ec), 64'(t0 + 17 + 18*(gap+1)));
   endtask

   initial begin
      set_exp(mac, ip);
      step(3);
      chk("reset_a", {a_en, a_val, a_addr, a_wd, a_busy, a_done, a_pc}, 64'd0);
      chk("reset_b", {b_en, b_val, b_addr, b_wd, b_busy, b_done, b_pc}, 64'd0);
      // auto-start on the first cycle after release, GAP=1
      rst_a = 0; rst_b = 0; t = cyc;
      clear_q(0); clear_q(1);
      step(1);
      chk("quiesce_a", {a_busy, a_en, a_val}, {1'b1, 1'b0, 1'b0});
      step(59);
      chk("nwr_a", 64'(wa.size()), 64'd18);
      check_seq(0, 0, t, 1, "auto");
      chk("pc_a1", 64'(a_pc), 64'd1);
      chk("run_a", {a_en, a_busy}, {1'b1, 1'b0});
      chk("idle_b", 64'(wb.size()), 64'd0);
      // GAP=0 on the manual-start instance
      t = cyc; start_b = 1; step(1); start_b = 0;
      step(40);
      chk("nwr_b", 64'(wb.size()), 64'd18);
      check_seq(1, 0, t, 0, "gap0");
      chk("pc_b1", 64'(b_pc), 64'd1);
      // ip change in RUN with auto_update
      clear_q(0);
      au_a = 1; ip = 32'hC0A80705; t = cyc;
      step(1);
      chk("au_drop", {a_en, a_busy}, {1'b0, 1'b1});
      step(59);
      set_exp(mac, ip);
      check_seq(0, 0, t, 1, "au");
      chk("pc_a2", 64'(a_pc), 64'd2);
      // same with auto_update off: nothing happens
      au_a = 0; ip = 32'hC0A80706;
      clear_q(0);
      step(40);
      chk("noau_wr", 64'(wa.size()), 64'd0);
      chk("noau_st", {a_en, a_pc}, {1'b1, 8'd2});
      // three starts during write k=5 collapse into one extra sequence
      clear_q(0);
      t = cyc; start_a = 1; step(1); start_a = 0;
      step(26);
      start_a = 1; step(1); start_a = 0; step(1);
      start_a = 1; step(1); start_a = 0; step(1);
      start_a = 1; step(1); start_a = 0;
      step(90);
      set_exp(mac, ip);
      chk("x3_nwr", 64'(wa.size()), 64'd36);
      check_seq(0, 0, t, 1, "x3s1");
      check_seq(0, 18, t + 53, 1, "x3s2");
      chk("x3_ndone", 64'(da.size()), 64'd2);
      chk("pc_a4", 64'(a_pc), 64'd4);
      // mac change mid-write: snapshot bytes, then one auto retrigger
      au_a = 1;
      clear_q(0);
      t = cyc; start_a = 1; step(1); start_a = 0;
      step(19);
      mac = 48'hAABBCCDDEEFF;
      step(100);
      chk("mc_nwr", 64'(wa.size()), 64'd36);
      set_exp(48'h112233445566, ip);
      check_seq(0, 0, t, 1, "mcs1");
      set_exp(mac, ip);
      check_seq(0, 18, t + 53, 1, "mcs2");
      chk("pc_a6", 64'(a_pc), 64'd6);
      // reset during write k=7, then manual restart from scratch
      clear_q(1);
      t = cyc; start_b = 1; step(1); start_b = 0;
      step(23);
      chk("rs_k7", {b_val, b_addr}, {1'b1, 5'd7});
      rst_b = 1; step(1);
      chk("rs_zero", {b_en, b_val, b_addr, b_wd, b_busy, b_done, b_pc}, 64'd0);
      rst_b = 0;
      clear_q(1);
      step(30);
      chk("rs_idle", {32'(wb.size()), 31'd0, b_busy}, 64'd0);
      t = cyc; start_b = 1; step(1); start_b = 0;
      step(40);
      chk("rs_nwr", 64'(wb.size()), 64'd18);
      check_seq(1, 0, t, 0, "rs");
      chk("pc_b_rs", 64'(b_pc), 64'd1);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
